dispatcher_rr: RTL
==================

# dispatcher_rr

Single-stream to dual-stream round-robin dispatcher: the counterpart of the two-input round-robin arbiter. It accepts one valid/ready input stream and distributes accepted words alternately across two output streams, skipping an output that cannot accept. Each output has a one-entry registered buffer. It sits in front of pairs of processing engines, fanning shared work out to them.

## Interface
- DWIDTH, 16, width of the data word on all streams
- PRIORITY_0, 1, when 1 output 0 receives the first word after reset; when 0 output 1 does
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_data  input  DWIDTH  input word
- in_ready  output  1  dispatcher accepts in_data this cycle
- out_0_valid  output  1  output 0 buffer holds a word
- out_0_data  output  DWIDTH  output 0 word
- out_0_ready  input  1  consumer 0 takes the word
- out_1_valid  output  1  output 1 buffer holds a word
- out_1_data  output  DWIDTH  output 1 word
- out_1_ready  input  1  consumer 1 takes the word

## Operation
- Per output k: buffer state full_k (drives out_k_valid), data_k (drives out_k_data). can_acc_k = !full_k || out_k_ready.
- in_ready = can_acc_0 || can_acc_1 (combinational; out_k_ready may propagate to in_ready).
- Transfer when in_valid && in_ready. Target selection:
  - both can_acc: target = output not granted last (last_grant register).
  - one can_acc: that output, regardless of last_grant.
- On transfer: data_target <= in_data, full_target <= 1, last_grant <= target.
- Pop of output k when out_k_valid && out_k_ready: full_k <= 0 unless same-cycle refill of k, then full_k stays 1 with new data.
- No transfer: last_grant unchanged; in_valid low never advances the pointer.
- Words never dropped or duplicated; per-output order equals input order of words sent there.
- out_k_data stable while out_k_valid high and out_k_ready low.
- in_data ignored when in_valid low.

## Timing
- Reset (reset high at a rising edge): out_0_valid = 0, out_1_valid = 0, out_0_data = 0, out_1_data = 0, last_grant = 1 if PRIORITY_0 else 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards buffered words; inputs presented during reset are not accepted.
- Latency: word accepted at edge N is on out_k_valid/out_k_data immediately after edge N (visible in cycle N+1).
- Throughput: one word per cycle sustained when both consumers hold ready high; alternates 0,1,0,1.
- Both buffers full, both readies low: in_ready = 0; buffers hold.
- Both full, only out_1_ready high: in_ready = 1; next word goes to output 1 even if last_grant = 1.
- Simultaneous pop and refill of the same output in one cycle: legal, no bubble.

## Structure
- Sub-module stream_reg_slice (one-entry buffer with full flag, push, pop, push-through-on-pop), instantiated twice; parameter DWIDTH.
- Selection and last_grant logic in dispatcher_rr top.
- Shared package: grant index encoding constants GRANT_0 = 1'b0, GRANT_1 = 1'b1, shared with the arbiter; no other typedefs.

## Test plan
- Reset: after reset deasserts, out_0_valid = 0, out_1_valid = 0, in_ready = 1.
- Alternation: both readies high, send 0xDEAD, 0xBEEF, 0x1234, 0x5678 back-to-back -> out_0 gets 0xDEAD then 0x1234, out_1 gets 0xBEEF then 0x5678, each one cycle after acceptance.
- Skip: out_0_ready low with out_0 holding 0xDEAD, send 0xBEEF, 0xCAFE -> 0xBEEF to out_1, in_ready low for 0xCAFE until a ready rises; out_0_data stays 0xDEAD.
- Backpressure full: both outputs full, both readies low for 5 cycles -> in_ready = 0, outputs stable; raise out_1_ready -> next word 0xF00D lands on out_1.
- Pointer hold: in_valid low for 3 cycles between words -> next word still goes to output not granted last.
- PRIORITY_0 = 0 instance: first word 0xAAAA after reset -> out_1; reset asserted with both buffers full -> both valids 0 next cycle.

Source files
------------

// File: rtl/dispatcher_rr_pkg.sv
// Grant index encoding shared by the round-robin arbiter and dispatcher.
package dispatcher_rr_pkg;

  localparam logic GRANT_0 = 1'b0;
  localparam logic GRANT_1 = 1'b1;

endpackage

// File: rtl/dispatcher_rr_stream_reg_slice.sv
// One-entry registered stream buffer: push, pop, and push-through on the
// same cycle the held word is consumed.
module stream_reg_slice #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              ready,
  output logic              valid,
  output logic [DWIDTH-1:0] data,
  output logic              can_acc
);

  logic              vld_p1;
  logic [DWIDTH-1:0] data_p1;

  // A slot is free if empty, or if its word leaves on this edge.
  assign can_acc = !vld_p1 || ready;
  assign valid   = vld_p1;
  assign data    = data_p1;

  // Stage p1: buffer register; data moves only on push so it holds under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (push) begin
      vld_p1  <= 1'b1;
      data_p1 <= push_data;
    end else if (vld_p1 && ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/dispatcher_rr.sv
// Round-robin dispatcher: fans one valid/ready stream out to two buffered
// outputs, alternating and skipping an output that cannot take a word.
module dispatcher_rr
  import dispatcher_rr_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int PRIORITY_0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_0_valid,
  output logic [DWIDTH-1:0] out_0_data,
  input  logic              out_0_ready,
  output logic              out_1_valid,
  output logic [DWIDTH-1:0] out_1_data,
  input  logic              out_1_ready
);

  localparam logic GRANT_RST = (PRIORITY_0 != 0) ? GRANT_1 : GRANT_0;

  logic can_acc_0;
  logic can_acc_1;
  logic last_grant;
  logic target;
  logic xfer;
  logic push_0;
  logic push_1;

  assign in_ready = can_acc_0 || can_acc_1;
  assign xfer     = in_valid && in_ready;
  assign push_0   = xfer && (target == GRANT_0);
  assign push_1   = xfer && (target == GRANT_1);

  // Alternate only when both sides are free; otherwise take whichever is.
  always_comb begin
    target = GRANT_0;
    if (can_acc_0 && can_acc_1) begin
      target = (last_grant == GRANT_0) ? GRANT_1 : GRANT_0;
    end else if (can_acc_1) begin
      target = GRANT_1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_RST;
    end else if (xfer) begin
      last_grant <= target;
    end
  end

  stream_reg_slice #(
    .DWIDTH(DWIDTH)
  ) u_slice_0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push_0),
    .push_data (in_data),
    .ready     (out_0_ready),
    .valid     (out_0_valid),
    .data      (out_0_data),
    .can_acc   (can_acc_0)
  );

  stream_reg_slice #(
    .DWIDTH(DWIDTH)
  ) u_slice_1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push_1),
    .push_data (in_data),
    .ready     (out_1_ready),
    .valid     (out_1_valid),
    .data      (out_1_data),
    .can_acc   (can_acc_1)
  );

endmodule
